// File: rtl/loader_pkg.sv
// Shared types for the program loader: FSM states and stream framing sizes.
// Pure declarations; no latency or backpressure of its own.
package loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_DATA = 3'd2,
        S_SUM  = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_e;

    localparam int LEN_BYTES  = 4;
    localparam int WORD_BYTES = 4;

    // States in which the byte stream is being consumed.
    function automatic logic is_rx(input state_e s);
        return (s == S_LEN) || (s == S_DATA) || (s == S_SUM);
    endfunction

endpackage

// File: rtl/byte_word_asm.sv
// Little-endian byte-to-word assembler; word_valid is combinational on the 4th byte.
// Holds shift register and byte index while byte_vld is low; clr discards a partial word.
module byte_word_asm
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_vld,
    input  logic [7:0]  byte_dat,
    output logic        word_valid,
    output logic [31:0] word
);

    localparam int SHIFT_W = (WORD_BYTES - 1) * 8;

    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic [1:0]         idx_q, idx_d;

    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        if (clr) begin
            shift_d = '0;
            idx_d   = '0;
        end else if (byte_vld) begin
            // Newest byte enters at the top so the first byte ends up in [7:0].
            shift_d = {byte_dat, shift_q[SHIFT_W-1:8]};
            idx_d   = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

    assign word_valid = byte_vld && !clr && (idx_q == 2'(WORD_BYTES - 1));
    assign word       = {byte_dat, shift_q};

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: length, data words, checksum; write strobe one cycle after a word's last byte.
// Accepts bytes only on in_valid && in_ready; stalls indefinitely while in_valid is low.
module prog_loader
    import loader_pkg::*;
#(
    parameter int          ADDR_W    = 16,
    parameter logic [63:0] BASE_ADDR = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_rst,
    output logic        done,
    output logic        err
);

    localparam logic [32:0]     CAP = 33'(1) << ADDR_W;
    localparam logic [ADDR_W:0] ONE = (ADDR_W + 1)'(1);

    state_e          state_q, state_d;
    logic            in_ready_q, in_ready_d;
    logic            mem_we_q, mem_we_d;
    logic [63:0]     mem_addr_q, mem_addr_d;
    logic [31:0]     mem_wdata_q, mem_wdata_d;
    logic            cpu_rst_q, cpu_rst_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [ADDR_W:0] wcnt_q, wcnt_d;
    logic [ADDR_W:0] n_q, n_d;
    logic [7:0]      csum_q, csum_d;

    logic            accept;
    logic            asm_clr;
    logic            asm_vld;
    logic            word_valid;
    logic [31:0]     word;

    assign accept  = in_valid && in_ready_q;
    assign asm_vld = accept && ((state_q == S_LEN) || (state_q == S_DATA));

    byte_word_asm u_asm (
        .clk        (clk),
        .rst        (rst),
        .clr        (asm_clr),
        .byte_vld   (asm_vld),
        .byte_dat   (in_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_comb begin
        state_d     = state_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rst_d   = cpu_rst_q;
        done_d      = done_q;
        err_d       = err_q;
        wcnt_d      = wcnt_q;
        n_d         = n_q;
        csum_d      = csum_q;
        asm_clr     = 1'b0;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d   = S_LEN;
                    wcnt_d    = '0;
                    csum_d    = '0;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    cpu_rst_d = 1'b1;
                    asm_clr   = 1'b1;
                end
            end
            S_LEN: begin
                if (word_valid) begin
                    if (word == 32'd0) begin
                        state_d = S_SUM;
                    end else if ({1'b0, word} > CAP) begin
                        state_d   = S_ERR;
                        err_d     = 1'b1;
                        cpu_rst_d = 1'b1;
                    end else begin
                        state_d = S_DATA;
                        n_d     = word[ADDR_W:0];
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    csum_d = csum_q + in_data;
                end
                if (word_valid) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = BASE_ADDR + (64'(wcnt_q) << 2);
                    mem_wdata_d = word;
                    wcnt_d      = wcnt_q + ONE;
                    if ((wcnt_q + ONE) == n_q) begin
                        state_d = S_SUM;
                    end
                end
            end
            S_SUM: begin
                if (accept) begin
                    if (in_data == csum_q) begin
                        state_d   = S_DONE;
                        done_d    = 1'b1;
                        cpu_rst_d = 1'b0;
                    end else begin
                        state_d   = S_ERR;
                        err_d     = 1'b1;
                        cpu_rst_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d = is_rx(state_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rst_q   <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            wcnt_q      <= '0;
            n_q         <= '0;
            csum_q      <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rst_q   <= cpu_rst_d;
            done_q      <= done_d;
            err_q       <= err_d;
            wcnt_q      <= wcnt_d;
            n_q         <= n_d;
            csum_q      <= csum_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_rst   = cpu_rst_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboarded bench for prog_loader: one instance at ADDR_W=16, one at ADDR_W=4.
// Writes are checked by a negedge monitor against queued expectations.
module tb_prog_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start_v    [2];
    logic        in_valid_v [2];
    logic [7:0]  in_data_v  [2];
    logic        in_ready_v [2];
    logic        mem_we_v   [2];
    logic [63:0] mem_addr_v [2];
    logic [31:0] mem_wdata_v[2];
    logic        cpu_rst_v  [2];
    logic        done_v     [2];
    logic        err_v      [2];

    prog_loader #(.ADDR_W(16), .BASE_ADDR(64'h0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]),
        .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]), .in_data(in_data_v[0]),
        .mem_we(mem_we_v[0]), .mem_addr(mem_addr_v[0]), .mem_wdata(mem_wdata_v[0]),
        .cpu_rst(cpu_rst_v[0]), .done(done_v[0]), .err(err_v[0])
    );

    prog_loader #(.ADDR_W(4), .BASE_ADDR(64'h0)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]),
        .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]), .in_data(in_data_v[1]),
        .mem_we(mem_we_v[1]), .mem_addr(mem_addr_v[1]), .mem_wdata(mem_wdata_v[1]),
        .cpu_rst(cpu_rst_v[1]), .done(done_v[1]), .err(err_v[1])
    );

    typedef struct packed {
        logic [63:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp0[$];
    wr_t exp1[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic expect_wr(input int d, input logic [63:0] a, input logic [31:0] w);
        wr_t e;
        e.addr = a;
        e.data = w;
        if (d == 0) exp0.push_back(e);
        else        exp1.push_back(e);
    endtask

    task automatic mon(input int d);
        wr_t e;
        int  sz;
        if (mem_we_v[d]) begin
            sz = (d == 0) ? exp0.size() : exp1.size();
            if (sz == 0) begin
                chk($sformatf("d%0d unexpected write @0x%0h", d, mem_addr_v[d]),
                    64'(mem_we_v[d]), 64'd0);
            end else begin
                e = (d == 0) ? exp0.pop_front() : exp1.pop_front();
                chk($sformatf("d%0d write addr", d), mem_addr_v[d], e.addr);
                chk($sformatf("d%0d write data", d), 64'(mem_wdata_v[d]), 64'(e.data));
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    task automatic idle(input int d, input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            in_valid_v[d] = 1'b0;
        end
    endtask

    task automatic pulse_start(input int d);
        @(negedge clk);
        in_valid_v[d] = 1'b0;
        start_v[d]    = 1'b1;
        @(negedge clk);
        start_v[d]    = 1'b0;
    endtask

    // Present one byte from a negedge and return just after the accepting posedge.
    task automatic send_byte(input int d, input logic [7:0] b, input bit gaps);
        int t;
        if (gaps) idle(d, $urandom_range(0, 2));
        @(negedge clk);
        in_valid_v[d] = 1'b1;
        in_data_v[d]  = b;
        t = 0;
        while (!in_ready_v[d] && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready_v[d]) chk($sformatf("d%0d in_ready timeout", d), 64'(in_ready_v[d]), 64'd1);
        else @(posedge clk);
    endtask

    task automatic send_list(input int d, input logic [7:0] q[$], input bit gaps);
        foreach (q[i]) send_byte(d, q[i], gaps);
    endtask

    // Word k of the pattern: bytes k, k^5A, C3, ~k (little-endian).
    task automatic load_pattern(input int d, input int unsigned n, input int nw,
                                input bit gaps, input bit send_sum, input bit bad_sum);
        logic [7:0]  q[$];
        logic [7:0]  cs;
        logic [31:0] nn;
        logic [7:0]  b0, b1, b2, b3;
        nn = n;
        cs = 8'h00;
        q  = {nn[7:0], nn[15:8], nn[23:16], nn[31:24]};
        for (int k = 0; k < nw; k++) begin
            b0 = 8'(k);
            b1 = 8'(k) ^ 8'h5A;
            b2 = 8'hC3;
            b3 = ~8'(k);
            q.push_back(b0); q.push_back(b1); q.push_back(b2); q.push_back(b3);
            cs = cs + b0 + b1 + b2 + b3;
            expect_wr(d, 64'(4 * k), {b3, b2, b1, b0});
        end
        if (send_sum) q.push_back(bad_sum ? (cs ^ 8'h01) : cs);
        pulse_start(d);
        send_list(d, q, gaps);
    endtask

    task automatic chk_status(input int d, input string tag, input logic e_done,
                              input logic e_err, input logic e_cpu_rst);
        idle(d, 3);
        chk($sformatf("%s done", tag),    64'(done_v[d]),     64'(e_done));
        chk($sformatf("%s err", tag),     64'(err_v[d]),      64'(e_err));
        chk($sformatf("%s cpu_rst", tag), 64'(cpu_rst_v[d]),  64'(e_cpu_rst));
        chk($sformatf("%s in_ready", tag), 64'(in_ready_v[d]), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] s[$];
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            start_v[d]    = 1'b0;
            in_valid_v[d] = 1'b0;
            in_data_v[d]  = 8'h00;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("reset cpu_rst",   64'(cpu_rst_v[0]),  64'd1);
        chk("reset done",      64'(done_v[0]),     64'd0);
        chk("reset err",       64'(err_v[0]),      64'd0);
        chk("reset in_ready",  64'(in_ready_v[0]), 64'd0);
        chk("reset mem_we",    64'(mem_we_v[0]),   64'd0);
        chk("reset mem_addr",  mem_addr_v[0],      64'd0);
        chk("reset mem_wdata", 64'(mem_wdata_v[0]), 64'd0);
        chk("reset d1 cpu_rst", 64'(cpu_rst_v[1]), 64'd1);

        // Two words; 0x13 + 0x6F = 0x82.
        expect_wr(0, 64'h0, 32'h0000_0013);
        expect_wr(0, 64'h4, 32'h0000_006F);
        s = {8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
             8'h6F, 8'h00, 8'h00, 8'h00, 8'h82};
        pulse_start(0);
        send_list(0, s, 1'b0);
        chk_status(0, "good sum", 1'b1, 1'b0, 1'b0);

        expect_wr(0, 64'h0, 32'h0000_0013);
        expect_wr(0, 64'h4, 32'h0000_006F);
        s[12] = 8'h94;
        pulse_start(0);
        send_list(0, s, 1'b0);
        chk_status(0, "bad sum", 1'b0, 1'b1, 1'b1);
        chk("held mem_addr",  mem_addr_v[0],        64'h4);
        chk("held mem_wdata", 64'(mem_wdata_v[0]),  64'h6F);

        s = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        pulse_start(0);
        send_list(0, s, 1'b0);
        chk_status(0, "empty load", 1'b1, 1'b0, 1'b0);
        chk("empty load mem_addr", mem_addr_v[0], 64'h4);

        load_pattern(1, 17, 0, 1'b0, 1'b0, 1'b0);
        chk_status(1, "n=17 cap16", 1'b0, 1'b1, 1'b1);
        load_pattern(1, 16, 16, 1'b0, 1'b1, 1'b0);
        chk_status(1, "n=16 cap16", 1'b1, 1'b0, 1'b0);

        load_pattern(0, 64, 64, 1'b0, 1'b1, 1'b0);
        chk_status(0, "64w no gaps", 1'b1, 1'b0, 1'b0);
        load_pattern(0, 64, 64, 1'b1, 1'b1, 1'b0);
        chk_status(0, "64w gaps", 1'b1, 1'b0, 1'b0);

        // Reset after 6 data bytes: word 0 was already written, word 1 is dropped.
        expect_wr(0, 64'h0, 32'h4433_2211);
        s = {8'h02, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        pulse_start(0);
        send_list(0, s, 1'b0);
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst in_ready",  64'(in_ready_v[0]), 64'd0);
        chk("midrst mem_addr",  mem_addr_v[0],      64'd0);
        chk("midrst mem_wdata", 64'(mem_wdata_v[0]), 64'd0);
        chk("midrst cpu_rst",   64'(cpu_rst_v[0]),  64'd1);
        chk("midrst done",      64'(done_v[0]),     64'd0);

        // AA + BB + CC + DD = 0x30E.
        expect_wr(0, 64'h0, 32'hDDCC_BBAA);
        s = {8'h01, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h0E};
        pulse_start(0);
        send_list(0, s, 1'b0);
        chk_status(0, "after rst", 1'b1, 1'b0, 1'b0);

        idle(0, 4);
        chk("d0 pending writes", 64'(exp0.size()), 64'd0);
        chk("d1 pending writes", 64'(exp1.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
